// File: rtl/rotate_left_serial.sv
// rotate_left_serial: serial rotator, one bit per clock, start/ready/done_tick handshake; ROT_DIR_EN adds a dir port for right rotation
module rotate_left_serial #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef ROT_DIR_EN
  input  logic              dir,
`endif
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic              ready,
  output logic              done_tick,
  output logic [DATA_W-1:0] y
);
  if (DATA_W != 2**AMT_W) begin : g_width_check
    $error("rotate_left_serial: DATA_W must equal 2**AMT_W");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state, state_next;
  logic [AMT_W-1:0]  count, count_next;
  logic [DATA_W-1:0] y_next;
  logic              right, right_next;
  logic              dir_in;
`ifdef ROT_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif
  // state, result and remaining-step registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      y     <= '0;
      count <= '0;
      right <= 1'b0;
    end else begin
      state <= state_next;
      y     <= y_next;
      count <= count_next;
      right <= right_next;
    end
  end
  // next-state, datapath update and handshake outputs
  always_comb begin
    state_next = state;
    y_next     = y;
    count_next = count;
    right_next = right;
    ready      = state == IDLE;
    done_tick  = state == DONE;
    case (state)
      IDLE: if (start) begin
        y_next     = a;
        count_next = amt;
        right_next = dir_in;
        state_next = amt == '0 ? DONE : SHIFT;
      end
      SHIFT: begin
        y_next     = right ? {y[0], y[DATA_W-1:1]} : {y[DATA_W-2:0], y[DATA_W-1]};
        count_next = count - 1'b1;
        state_next = count == AMT_W'(1) ? DONE : SHIFT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rotate_left_serial.sv
// tb_rotate_left_serial: directed and random checks of rotate_left_serial against an arithmetic rotate model
module tb_rotate_left_serial;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] a = '0;
  logic [2:0] amt = '0;
  logic       ready, done_tick;
  logic [7:0] y;
  int total = 0;
  int bad = 0;

  rotate_left_serial #(.DATA_W(8), .AMT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef ROT_DIR_EN
    .dir(dir),
`endif
    .a(a),
    .amt(amt),
    .ready(ready),
    .done_tick(done_tick),
    .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model(input int av, input int am, input logic dv);
    return dv ? ((av >> am) | (av << (8 - am))) & 255
              : ((av << am) | (av >> (8 - am))) & 255;
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [2:0] am, input logic dv, input int poke);
    int n = 0;
    bit done = 0;
    bit rdy_seen = 0;
    int exp = model(int'(av), int'(am), dv);
    chk("ready_idle", int'(ready), 1);
    start = 1'b1; a = av; amt = am; dir = dv;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (ready) rdy_seen = 1;
      done = done_tick;
      start = n == poke;
      a = n == poke ? 8'hFF : $urandom_range(0, 255);
      amt = 3'($urandom_range(0, 7));
    end
    start = 1'b0;
    chk("latency", n, int'(am) + 1);
    chk("y_done", int'(y), exp);
    chk("ready_low_busy", int'(rdy_seen), 0);
    @(negedge clk);
    chk("tick_single", int'(done_tick), 0);
    chk("ready_back", int'(ready), 1);
    chk("y_hold", int'(y), exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_y", int'(y), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_tick", int'(done_tick), 0);
    run_op(8'h81, 3'd1, 1'b0, 0);
    run_op(8'hA5, 3'd0, 1'b0, 0);
    run_op(8'h01, 3'd7, 1'b0, 0);
    run_op(8'h0F, 3'd4, 1'b0, 2);
    // reset in cycle 3 of an amt=6 op, with a competing start
    start = 1'b1; a = 8'h5B; amt = 3'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_y", int'(y), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_tick", int'(done_tick), 0);
    reset = 1'b0; start = 1'b0;
    run_op(8'h3C, 3'd3, 1'b0, 0);
`ifdef ROT_DIR_EN
    run_op(8'h01, 3'd1, 1'b1, 0);
    run_op(8'h01, 3'd1, 1'b0, 0);
`endif
    for (int i = 0; i < 40; i++) begin
`ifdef ROT_DIR_EN
      run_op(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
`else
      run_op(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b0, 0);
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
